cic_decim_ctrl: RTL and testbench

//  Sequencer for a first-order CIC decimator datapath. Owns the decimation timing:

---
 rtl/cic_decim_ctrl_pkg.sv | 15 +
 rtl/cic_decim_ctrl_if.sv | 11 +
 rtl/cic_decim_ctrl_out_buf.sv | 106 ++++++++++
 rtl/cic_decim_ctrl.sv | 106 ++++++++++
 tb/tb_cic_decim_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cic_decim_ctrl_pkg.sv
// rtl/cic_decim_ctrl_pkg.sv - CIC decimator sequencer state encoding and default widths
package cic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } cic_ctrl_state_e;

    localparam int CIC_CNT_W        = 10;
    localparam int CIC_DATA_W       = 10;
    localparam int CIC_SETTLE_DUMPS = 2;

endpackage

// File: rtl/cic_decim_ctrl_if.sv
// rtl/cic_decim_ctrl_if.sv - valid/ready sample stream from the CIC sequencer to its consumer
interface cic_decim_ctrl_if #(
    parameter int DATA_W = cic_pkg::CIC_DATA_W
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/cic_decim_ctrl_out_buf.sv
// rtl/cic_decim_ctrl_out_buf.sv - output sample buffer with sticky overflow detect
// CIC_CTRL_SKID_EN selects a 2-entry FIFO; otherwise a single holding register.
module cic_out_buf #(
    parameter int DATA_W = cic_pkg::CIC_DATA_W
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              ovf_clr_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              overflow_o
);
    logic pop;
    logic full;
    logic accept;
    logic ovf_q, ovf_d;

    assign pop    = out_valid_o && out_ready_i;
    assign accept = push_i && (!full || pop);

`ifdef CIC_CTRL_SKID_EN
    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;

    assign full        = (cnt_q == 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, accept} - {1'b0, pop};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    assign full        = valid_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        data_d  = accept ? push_data_i : data_q;
        valid_d = accept || (valid_q && !pop);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
`endif

    // A drop this cycle must win over a simultaneous clear request.
    always_comb begin
        ovf_d = ovf_q;
        if (push_i && full && !pop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow_o = ovf_q;
endmodule

// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - first-order CIC decimator sequencer: clear, dump timing, settle discard
// Output buffer depth selected by CIC_CTRL_SKID_EN (see cic_out_buf).
module cic_decim_ctrl
    import cic_pkg::*;
#(
    parameter int CNT_W        = CIC_CNT_W,
    parameter int DATA_W       = CIC_DATA_W,
    parameter int SETTLE_DUMPS = CIC_SETTLE_DUMPS
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [CNT_W-1:0]  ratio_i,
    output logic              cic_clr_o,
    output logic              cic_dump_o,
    input  logic [DATA_W-1:0] cic_data_i,
    cic_decim_ctrl_if.master  out_if,
    output logic              busy_o,
    output logic [1:0]        state_o,
    output logic              overflow_o,
    input  logic              overflow_clr_i
);
    localparam int SW = $clog2(SETTLE_DUMPS + 1);

    cic_ctrl_state_e  state_q, state_d;
    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
    logic             cap_pend_q, cap_pend_d;
    logic             clr, dump;

    always_comb begin
        state_d      = state_q;
        ratio_d      = ratio_q;
        dec_cnt_d    = dec_cnt_q;
        settle_cnt_d = settle_cnt_q;
        cap_pend_d   = 1'b0;
        clr          = 1'b0;
        dump         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CLEAR;
                    ratio_d = (ratio_i == '0) ? CNT_W'(1) : ratio_i;
                end
            end
            ST_CLEAR: begin
                clr          = 1'b1;
                dec_cnt_d    = '0;
                settle_cnt_d = '0;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE, ST_RUN: begin
                dump      = (dec_cnt_q == ratio_q);
                dec_cnt_d = dump ? '0 : dec_cnt_q + CNT_W'(1);
                if (dump && state_q == ST_SETTLE) begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                    if (settle_cnt_d == SW'(SETTLE_DUMPS)) begin
                        state_d = ST_RUN;
                    end
                end
                // Datapath output lands one cycle after the dump; capture then.
                cap_pend_d = dump && (state_q == ST_RUN);
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && stop_i) begin
            state_d   = ST_IDLE;
            dec_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            ratio_q      <= CNT_W'(1);
            dec_cnt_q    <= '0;
            settle_cnt_q <= '0;
            cap_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ratio_q      <= ratio_d;
            dec_cnt_q    <= dec_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            cap_pend_q   <= cap_pend_d;
        end
    end

    cic_out_buf #(.DATA_W(DATA_W)) u_out_buf (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .push_i      (cap_pend_q),
        .push_data_i (cic_data_i),
        .ovf_clr_i   (overflow_clr_i),
        .out_data_o  (out_if.out_data),
        .out_valid_o (out_if.out_valid),
        .out_ready_i (out_if.out_ready),
        .overflow_o  (overflow_o)
    );

    assign cic_clr_o  = clr;
    assign cic_dump_o = dump;
    assign busy_o     = (state_q != ST_IDLE);
    assign state_o    = state_q;
endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb/tb_cic_decim_ctrl.sv - scoreboard bench for cic_decim_ctrl against a timeline reference model
module tb_cic_decim_ctrl;
    localparam int CNT_W  = 10;
    localparam int DATA_W = 10;
    localparam int SD     = 2;
`ifdef CIC_CTRL_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    localparam int NEVER = 32'h7fff_ffff;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0, stop = 1'b0;
    logic [CNT_W-1:0]  ratio = '0;
    logic              clr_o, dump_o, busy_o, ovf_o;
    logic [1:0]        state_o;
    logic [DATA_W-1:0] cic_data = '0;
    logic              ready = 1'b1;
    logic              ovf_clr = 1'b0;

    cic_decim_ctrl_if #(.DATA_W(DATA_W)) sif ();
    assign sif.out_ready = ready;

    cic_decim_ctrl #(.CNT_W(CNT_W), .DATA_W(DATA_W), .SETTLE_DUMPS(SD)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .start_i        (start),
        .stop_i         (stop),
        .ratio_i        (ratio),
        .cic_clr_o      (clr_o),
        .cic_dump_o     (dump_o),
        .cic_data_i     (cic_data),
        .out_if         (sif.master),
        .busy_o         (busy_o),
        .state_o        (state_o),
        .overflow_o     (ovf_o),
        .overflow_clr_i (ovf_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Session timeline: clear at clear_cyc, dumps every r+1 clocks after, stop at stop_cyc.
    bit                active = 1'b0;
    int                clear_cyc = 0, stop_cyc = NEVER, r = 1;
    logic [DATA_W-1:0] exp_q[$];
    bit                ovf_exp = 1'b0;
    int                vectors = 0, miscompares = 0;

    function automatic int exp_state(int c);
        int n, k;
        if (!active || c < clear_cyc || c > stop_cyc) return 0;
        if (c == clear_cyc) return 1;
        n = c - clear_cyc;
        k = n / (r + 1);
        return (k < SD || (k == SD && (n % (r + 1)) == 0)) ? 2 : 3;
    endfunction

    function automatic bit exp_dump(int c);
        return exp_state(c) >= 2 && ((c - clear_cyc) % (r + 1)) == 0;
    endfunction

    function automatic bit exp_capture(int c);
        return exp_dump(c - 1) && exp_state(c - 1) == 3;
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        int st;
        bit mv, pop, push;
        if (rstn) begin
            st = exp_state(cyc);
            mv = (exp_q.size() != 0);
            chk("state", state_o, st);
            chk("busy", busy_o, st != 0);
            chk("clr", clr_o, st == 1);
            chk("dump", dump_o, exp_dump(cyc));
            chk("overflow", ovf_o, ovf_exp);
            chk("valid", sif.out_valid, mv);
            if (mv) chk("data", sif.out_data, exp_q[0]);
            pop  = mv && ready;
            push = exp_capture(cyc);
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                if (exp_q.size() < CAP) exp_q.push_back(cic_data);
                else ovf_exp = 1'b1;
            end
            if (!(push && exp_q.size() == CAP && !pop && ovf_exp) || !push) begin
                if (!(push && !pop && exp_q.size() == CAP) && ovf_clr && !(push && ovf_exp && exp_q.size() == CAP && !pop))
                    ovf_exp = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 cic_data = DATA_W'($urandom);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(int n);
        repeat (n) tick();
    endtask

    task automatic do_start(int rv, bit with_stop);
        start = 1'b1;
        stop  = with_stop;
        ratio = CNT_W'(rv);
        if (exp_state(cyc) == 0) begin
            active    = 1'b1;
            clear_cyc = cyc + 1;
            r         = (rv == 0) ? 1 : rv;
            stop_cyc  = NEVER;
        end
        tick();
        start = 1'b0;
        stop  = 1'b0;
        ratio = CNT_W'($urandom);
    endtask

    task automatic do_stop(bit with_start);
        if (exp_dump(cyc)) tick();
        stop  = 1'b1;
        start = with_start;
        if (exp_state(cyc) != 0) stop_cyc = cyc;
        tick();
        stop  = 1'b0;
        start = 1'b0;
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, "_state"}, state_o, 0);
        chk({nm, "_clr"}, clr_o, 0);
        chk({nm, "_dump"}, dump_o, 0);
        chk({nm, "_valid"}, sif.out_valid, 0);
        chk({nm, "_data"}, sif.out_data, 0);
        chk({nm, "_busy"}, busy_o, 0);
        chk({nm, "_ovf"}, ovf_o, 0);
    endtask

    initial begin
        int guard;
        #2;
        chk_all_zero("reset");
        wait_cycles(3);
        rstn = 1'b1;
        wait_cycles(2);

        // ratio 3: clear, dumps every 4 clocks, first sample after 3rd dump
        do_start(3, 1'b0);
        wait_cycles(40);
        do_stop(1'b0);
        wait_cycles(4);

        // ratio 0 runs as ratio 1
        do_start(0, 1'b0);
        wait_cycles(20);
        do_stop(1'b0);
        wait_cycles(4);

        // consumer stall -> overflow, held data is the oldest sample
        do_start(2, 1'b0);
        wait_cycles(16);
        ready = 1'b0;
        wait_cycles(12);
        ready = 1'b1;
        wait_cycles(8);

        // clear held high during a stall: drop cycles must still set overflow
        ready   = 1'b0;
        ovf_clr = 1'b1;
        wait_cycles(12);
        ovf_clr = 1'b0;
        wait_cycles(6);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        ready   = 1'b1;
        wait_cycles(6);

        // stop the cycle after a RUN dump: pending sample still delivered
        guard = 0;
        while (!exp_capture(cyc) && guard < 50) begin
            tick();
            guard++;
        end
        chk("stop_align", guard < 50, 1);
        do_stop(1'b0);
        wait_cycles(10);

        // start+stop together: IDLE -> CLEAR, RUN -> IDLE
        do_start(1, 1'b1);
        wait_cycles(20);
        do_stop(1'b1);
        wait_cycles(4);

        // randomized sessions
        repeat (8) begin
            do_start($urandom_range(0, 4), 1'b0);
            repeat ($urandom_range(20, 60)) begin
                ready   = ($urandom_range(0, 2) != 0);
                ovf_clr = ($urandom_range(0, 7) == 0);
                tick();
            end
            ovf_clr = 1'b0;
            do_stop(1'b0);
            ready = 1'b1;
            wait_cycles(6);
        end

        // asynchronous reset mid-RUN with a buffered sample
        do_start(1, 1'b0);
        wait_cycles(15);
        ready = 1'b0;
        wait_cycles(5);
        #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("async_rst");
        exp_q.delete();
        ovf_exp = 1'b0;
        active  = 1'b0;
        tick();
        rstn  = 1'b1;
        ready = 1'b1;
        wait_cycles(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
